// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode sequencer: prefix decode, typematic suppression, ROM lookup, one event per press.
// Optional `KBD_SHIFT_EN adds left/right shift tracking with upper-case folding of a..z.
module ps2_key_sequencer #(
  parameter int         CNT_W    = 8,
  parameter logic [7:0] BRK_CODE = 8'hF0,
  parameter logic [7:0] EXT_CODE = 8'hE0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       sc_data,
  input  logic             sc_valid,
  output logic             sc_ready,
  output logic [7:0]       lut_scancode,
  input  logic [7:0]       lut_ascii,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [7:0]       key_scancode,
  output logic [7:0]       key_ascii,
  output logic             key_ext,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_LOOK1, S_LOOK2, S_EMIT
  } state_t;

  state_t     state, state_nxt;
  logic       lut_ext;
  logic [7:0] held_code;
  logic       held_ext;
  logic       accept;
  logic       start_look, look_ext;
  logic       emit;
  logic       brk_hit, brk_ext;
  logic       is_junk, is_prefix;
  logic [7:0] ascii_adj;

`ifdef KBD_SHIFT_EN
  logic shift_l, shift_r;
  logic shift_make, shift_brk;
  logic is_shift;
  assign is_shift = (sc_data == 8'h12) || (sc_data == 8'h59);
`endif

  assign accept    = sc_valid && sc_ready;
  assign is_junk   = (sc_data == 8'h00) || (sc_data == 8'hFF);
  assign is_prefix = (sc_data == BRK_CODE) || (sc_data == EXT_CODE);
  assign sc_ready  = (state == S_IDLE) || (state == S_BRK) ||
                     (state == S_EXT)  || (state == S_EXT_BRK);
  assign key_valid = (state == S_EMIT);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_look = 1'b0;
    look_ext   = 1'b0;
    emit       = 1'b0;
    brk_hit    = 1'b0;
    brk_ext    = 1'b0;
`ifdef KBD_SHIFT_EN
    shift_make = 1'b0;
    shift_brk  = 1'b0;
`endif
    case (state)
      S_IDLE: if (accept) begin
        if (sc_data == BRK_CODE)      state_nxt = S_BRK;
        else if (sc_data == EXT_CODE) state_nxt = S_EXT;
        else if (is_junk)             state_nxt = S_IDLE;
`ifdef KBD_SHIFT_EN
        else if (is_shift)            shift_make = 1'b1;
`endif
        // A make code matching the held key is a typematic repeat.
        else if (!(key_held && !held_ext && held_code == sc_data)) begin
          start_look = 1'b1;
          state_nxt  = S_LOOK1;
        end
      end
      S_EXT: if (accept) begin
        if (sc_data == BRK_CODE)      state_nxt = S_EXT_BRK;
        else if (sc_data == EXT_CODE) state_nxt = S_IDLE;
        else if (!(key_held && held_ext && held_code == sc_data)) begin
          start_look = 1'b1;
          look_ext   = 1'b1;
          state_nxt  = S_LOOK1;
        end else                      state_nxt = S_IDLE;
      end
      S_BRK, S_EXT_BRK: if (accept) begin
        state_nxt = S_IDLE;
        if (!is_prefix) begin
          brk_hit = 1'b1;
          brk_ext = (state == S_EXT_BRK);
`ifdef KBD_SHIFT_EN
          shift_brk = (state == S_BRK) && is_shift;
`endif
        end
      end
      S_LOOK1: state_nxt = S_LOOK2;
      S_LOOK2: begin
        emit      = 1'b1;
        state_nxt = S_EMIT;
      end
      S_EMIT: if (key_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef KBD_SHIFT_EN
  always_comb begin
    ascii_adj = lut_ascii;
    if ((shift_l || shift_r) && lut_ascii >= 8'h61 && lut_ascii <= 8'h7A)
      ascii_adj = lut_ascii - 8'h20;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else if (shift_make || shift_brk) begin
      if (sc_data == 8'h12) shift_l <= shift_make;
      else                  shift_r <= shift_make;
    end
  end
`else
  assign ascii_adj = lut_ascii;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lut_scancode <= 8'h00;
      lut_ext      <= 1'b0;
      key_scancode <= 8'h00;
      key_ascii    <= 8'h00;
      key_ext      <= 1'b0;
      key_held     <= 1'b0;
      held_code    <= 8'h00;
      held_ext     <= 1'b0;
      press_count  <= '0;
    end else begin
      if (start_look) begin
        lut_scancode <= sc_data;
        lut_ext      <= look_ext;
      end
      if (emit) begin
        key_scancode <= lut_scancode;
        key_ascii    <= lut_ext ? 8'h00 : ascii_adj;
        key_ext      <= lut_ext;
        key_held     <= 1'b1;
        held_code    <= lut_scancode;
        held_ext     <= lut_ext;
        press_count  <= press_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (brk_hit && key_held && held_code == sc_data && held_ext == brk_ext) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a registered lookup-ROM model.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] sc_data = 8'h00;
  logic       sc_valid = 1'b0;
  logic       sc_ready;
  logic [7:0] lut_scancode;
  logic [7:0] lut_ascii;
  logic       key_valid;
  logic       key_ready = 1'b1;
  logic [7:0] key_scancode;
  logic [7:0] key_ascii;
  logic       key_ext;
  logic       key_held;
  logic [7:0] press_count;

  int         vecs = 0;
  int         errs = 0;
  int         ev_cnt = 0;
  logic [7:0] exp_count = 8'h00;

  always #5 clk = ~clk;

  ps2_key_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .sc_data(sc_data), .sc_valid(sc_valid), .sc_ready(sc_ready),
    .lut_scancode(lut_scancode), .lut_ascii(lut_ascii),
    .key_valid(key_valid), .key_ready(key_ready), .key_scancode(key_scancode),
    .key_ascii(key_ascii), .key_ext(key_ext), .key_held(key_held), .press_count(press_count)
  );

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h1C:   rom = 8'h61;
      8'h32:   rom = 8'h62;
      8'h75:   rom = 8'h38;
      8'h12:   rom = 8'h00;
      8'h59:   rom = 8'h00;
      default: rom = 8'h3F;
    endcase
  endfunction

  always @(posedge clk) lut_ascii <= rom(lut_scancode);

  always @(posedge clk) if (clrn && key_valid && key_ready) ev_cnt++;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!sc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!sc_ready) begin
      vecs++; errs++;
      $display("FAIL send_timeout byte=%h sc_ready=%b required 1", b, sc_ready);
    end
    sc_data  = b;
    sc_valid = 1'b1;
    @(negedge clk);
    sc_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!key_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (key_valid !== 1'b1) begin
      errs++;
      $display("FAIL %s_wait key_valid=%b required 1", tag, key_valid);
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    #3;
    vecs++;
    if ({key_valid, key_held, key_ext, key_ascii, key_scancode, press_count, lut_scancode} !== 36'h0) begin
      errs++;
      $display("FAIL reset_outputs kv=%b kh=%b ke=%b ka=%h ks=%h cnt=%h lut=%h required all 0",
               key_valid, key_held, key_ext, key_ascii, key_scancode, press_count, lut_scancode);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    vecs++;
    if (sc_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_sc_ready got=%b required 1", sc_ready);
    end
  endtask

  task automatic test_errors();
    int base = ev_cnt;
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'hE0); send_byte(8'hE0);
    send_byte(8'hF0); send_byte(8'hE0);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0);
    settle();
    vecs++;
    if (ev_cnt - base !== 0 || press_count !== exp_count || key_held !== 1'b0) begin
      errs++;
      $display("FAIL errors_dropped events=%0d cnt=%h held=%b required 0 %h 0",
               ev_cnt - base, press_count, key_held, exp_count);
    end
  endtask

  task automatic test_make_break();
    int base = ev_cnt;
    send_byte(8'h1C);
    exp_count++;
    vecs++;
    if (key_valid !== 1'b0 || sc_ready !== 1'b0) begin
      errs++;
      $display("FAIL mb_look1 kv=%b sc_ready=%b required 0 0", key_valid, sc_ready);
    end
    @(negedge clk);
    vecs++;
    if (key_valid !== 1'b0) begin
      errs++;
      $display("FAIL mb_look2 kv=%b required 0", key_valid);
    end
    @(negedge clk);
    vecs++;
    if (key_valid !== 1'b1 || key_ascii !== 8'h61 || key_scancode !== 8'h1C ||
        key_ext !== 1'b0 || key_held !== 1'b1 || press_count !== exp_count) begin
      errs++;
      $display("FAIL mb_event kv=%b ka=%h ks=%h ke=%b kh=%b cnt=%h required 1 61 1c 0 1 %h",
               key_valid, key_ascii, key_scancode, key_ext, key_held, press_count, exp_count);
    end
    send_byte(8'hF0); send_byte(8'h1C);
    settle();
    vecs++;
    if (key_held !== 1'b0 || ev_cnt - base !== 1 || key_ascii !== 8'h61) begin
      errs++;
      $display("FAIL mb_break kh=%b events=%0d ka=%h required 0 1 61", key_held, ev_cnt - base, key_ascii);
    end
  endtask

  task automatic test_repeat();
    int base = ev_cnt;
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    exp_count++;
    settle();
    vecs++;
    if (ev_cnt - base !== 1 || press_count !== exp_count || key_held !== 1'b0) begin
      errs++;
      $display("FAIL repeat events=%0d cnt=%h held=%b required 1 %h 0",
               ev_cnt - base, press_count, key_held, exp_count);
    end
  endtask

  task automatic test_ext();
    int base = ev_cnt;
    send_byte(8'hE0); send_byte(8'h75);
    exp_count++;
    settle();
    vecs++;
    if (key_scancode !== 8'h75 || key_ext !== 1'b1 || key_ascii !== 8'h00 || key_held !== 1'b1) begin
      errs++;
      $display("FAIL ext_event ks=%h ke=%b ka=%h kh=%b required 75 1 00 1",
               key_scancode, key_ext, key_ascii, key_held);
    end
    send_byte(8'hF0); send_byte(8'h75);
    settle();
    vecs++;
    if (key_held !== 1'b1) begin
      errs++;
      $display("FAIL ext_plain_break_ignored kh=%b required 1", key_held);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    settle();
    vecs++;
    if (key_held !== 1'b0 || ev_cnt - base !== 1 || press_count !== exp_count) begin
      errs++;
      $display("FAIL ext_break kh=%b events=%0d cnt=%h required 0 1 %h",
               key_held, ev_cnt - base, press_count, exp_count);
    end
  endtask

  task automatic test_shift();
    int base = ev_cnt;
    send_byte(8'h12); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    settle();
    vecs++;
`ifdef KBD_SHIFT_EN
    exp_count++;
    if (ev_cnt - base !== 1 || key_ascii !== 8'h41 || press_count !== exp_count || key_held !== 1'b0) begin
      errs++;
      $display("FAIL shift events=%0d ka=%h cnt=%h kh=%b required 1 41 %h 0",
               ev_cnt - base, key_ascii, press_count, key_held, exp_count);
    end
`else
    exp_count += 8'd2;
    if (ev_cnt - base !== 2 || key_ascii !== 8'h61 || press_count !== exp_count || key_held !== 1'b0) begin
      errs++;
      $display("FAIL shift events=%0d ka=%h cnt=%h kh=%b required 2 61 %h 0",
               ev_cnt - base, key_ascii, press_count, key_held, exp_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    int bad = 0;
    key_ready = 1'b0;
    send_byte(8'h32);
    exp_count++;
    wait_valid("bp");
    sc_data  = 8'h1C;
    sc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sc_ready !== 1'b0 || key_valid !== 1'b1 || key_ascii !== 8'h62 ||
          key_scancode !== 8'h32 || press_count !== exp_count) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL bp_stall bad_cycles=%0d sc_ready=%b kv=%b ka=%h cnt=%h required 0 1 62 %h",
               bad, sc_ready, key_valid, key_ascii, press_count, exp_count);
    end
    sc_valid  = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (key_valid !== 1'b0 || lut_scancode !== 8'h32) begin
      errs++;
      $display("FAIL bp_release kv=%b lut=%h required 0 32", key_valid, lut_scancode);
    end
    send_byte(8'hF0); send_byte(8'h32);
    settle();
  endtask

  task automatic test_wrap();
    logic tog = 1'b0;
    while (exp_count != 8'hFF) begin
      send_byte(tog ? 8'h1C : 8'h32);
      tog = ~tog;
      exp_count++;
    end
    settle();
    vecs++;
    if (press_count !== 8'hFF) begin
      errs++;
      $display("FAIL wrap_255 cnt=%h required ff", press_count);
    end
    send_byte(tog ? 8'h1C : 8'h32);
    exp_count++;
    settle();
    vecs++;
    if (press_count !== 8'h00 || key_held !== 1'b1) begin
      errs++;
      $display("FAIL wrap_0 cnt=%h kh=%b required 00 1", press_count, key_held);
    end
  endtask

  task automatic test_reset_mid_emit();
    key_ready = 1'b0;
    send_byte(8'hE0); send_byte(8'h75);
    wait_valid("rst");
    clrn = 1'b0;
    #1;
    vecs++;
    if (key_valid !== 1'b0 || press_count !== 8'h00 || key_ascii !== 8'h00 || key_held !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_emit kv=%b cnt=%h ka=%h kh=%b required 0 00 00 0",
               key_valid, press_count, key_ascii, key_held);
    end
    @(negedge clk);
    clrn      = 1'b1;
    key_ready = 1'b1;
    @(negedge clk);
    vecs++;
    if (key_valid !== 1'b0 || sc_ready !== 1'b1) begin
      errs++;
      $display("FAIL post_reset kv=%b sc_ready=%b required 0 1", key_valid, sc_ready);
    end
  endtask

  initial begin
    test_reset();
    test_errors();
    test_make_break();
    test_repeat();
    test_ext();
    test_shift();
    test_backpressure();
    test_wrap();
    test_reset_mid_emit();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
